hazard_ctrl_param: RTL and testbench
====================================

Name: hazard_ctrl_param

Overview:
Parametrised pipeline hazard controller for the in-order core. It handles:
- register forwarding selection for NUM_RS source operands across NUM_PROD producer slots;
- a generalised stall/bubble chain over NUM_STAGES pipeline registers;
- fetch redirection;
- an IRQ drain state machine with a registered take pulse.

It sits beside the pipeline and drives the stall/flush inputs of every pipeline register and the PC steering of fetch.

Parameters:
- NUM_RS, 2, source operands per instruction.
- NUM_PROD, 3, producer slots. Slot 0 is the instruction in EX; slots 1..NUM_PROD-1 are older stages, youngest first. Must be >= 2.
- NUM_STAGES, 4, pipeline registers. Index 0 is IF/ID; higher indices are older.
- REG_AW, 5, register address width.
- SELW, $clog2(NUM_PROD), forwarding select width (derived).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- rs_d_i  in  NUM_RS*REG_AW  source registers of the instruction in decode.
- rs_e_i  in  NUM_RS*REG_AW  source registers of the instruction in EX.
- prod_rd_i  in  NUM_PROD*REG_AW  destination register per producer slot.
- prod_wr_i  in  NUM_PROD  producer writes rd.
- prod_rdy_i  in  NUM_PROD  producer result is available; 0 for a pending load or CSR read.
- fwd_sel_o  out  NUM_RS*SELW  per operand: 0 = register file, k = producer slot k.
- valid_i  in  NUM_STAGES  instruction valid per pipeline register.
- stall_req_i  in  NUM_STAGES  external stall cause per register.
- flush_req_i  in  NUM_STAGES  external flush cause per register.
- stall_o  out  NUM_STAGES  final stall per register.
- flush_o  out  NUM_STAGES  final flush per register.
- trap_i  in  1  trap taken in MEM.
- mret_i  in  1  the trap is an MRET.
- branch_i  in  1  EX branch or jump taken.
- csr_wr_i  in  1  CSR write retiring in MEM.
- irq_pend_i  in  1  OR of enabled pending interrupts.
- irq_en_i  in  1  global enable (mstatus.MIE or U-mode).
- new_pc_en_o  out  1  fetch redirect.
- pc_sel_o  out  2  redirect source: 0 JUMP, 1 TRAP, 2 MEPC, 3 CSRW.
- take_irq_o  out  1  one-cycle interrupt take pulse to the CSR file.

Behaviour:
- Forwarding (combinational):
  - Per operand j, if rs_e[j] != 0, select the lowest k in 1..NUM_PROD-1 with prod_wr[k] and prod_rd[k] == rs_e[j].
  - Otherwise select 0.
  - x0 never forwards.
- Data hazard (combinational):
  - For each j, find the youngest slot k in 0..NUM_PROD-1 matching rs_d[j] (same rules as forwarding).
  - If that slot has prod_rdy = 0, raise an internal stall cause at register 0.
  - Older matches behind a ready younger match do not stall.
- IRQ FSM, states RUN, DRAIN, TAKE. Resets to RUN.
  - RUN: irq_pend_i & irq_en_i -> DRAIN.
  - DRAIN: stall cause at register 0.
    - If !(irq_pend_i & irq_en_i) or trap_i -> RUN.
    - Else if valid_i[NUM_STAGES-1:1] == 0 -> TAKE.
  - TAKE: take_irq_o = 1 (registered, exactly one cycle), new_pc_en_o = 1, pc_sel = TRAP, flush_o[0] = 1 -> RUN.
  - trap_i in TAKE has priority. take_irq_o is still asserted because it is registered, so the CSR file must give the trap priority. The bench checks that the redirect is TRAP from trap_i.
- Redirect priority (combinational, except TAKE):
  - trap_i (MEPC if mret_i else TRAP) > TAKE > branch_i (JUMP) > csr_wr_i (CSRW).
  - new_pc_en_o = 0 otherwise.
- Flush causes (internal cause ORed with flush_req_i):
  - trap_i flushes registers 0..2.
  - csr_wr_i flushes registers 0..2.
  - branch_i flushes registers 0..1.
  - Registers >= 3 see flush_req_i only.
- Stall chain:
  - cause[k] = (internal | stall_req_i[k]) & ~flush_o_cause[k].
  - stall_o[NUM_STAGES-1] = cause[NUM_STAGES-1].
  - stall_o[k] = cause[k] | stall_o[k+1].
- Bubble:
  - For k >= 1, flush_o[k] = flush cause[k] | (stall_o[k-1] & ~stall_o[k]).
  - flush_o[0] = flush cause[0].
  - A flush and a stall on the same register: flush wins; the stall is masked by the cause definition.
- Reset values: state = RUN, take_irq_o = 0, counters = 0. Combinational outputs follow their inputs.
- Reset mid-DRAIN returns to RUN with no pulse.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
  - Defined: adds outputs perf_stall_cnt_o (32), perf_flush_cnt_o (32) and perf_irq_lat_o (16).
    - perf_stall_cnt_o counts cycles with stall_o[0].
    - perf_flush_cnt_o counts cycles with any internal flush cause.
    - perf_irq_lat_o holds the DRAIN length of the last taken IRQ.
    - Counters saturate at all-ones and clear on rst_i.
  - Undefined: no counter ports or logic.

Test Plan:
- Load-use stall:
  - Stimulus: prod_rd[0] = 5, prod_wr[0] = 1, prod_rdy[0] = 0, rs_d[0] = 5, 4 stages.
  - Response: stall_o = 4'b0001, flush_o = 4'b0010. When prod_rdy[0] = 1 (next cycle), stall_o = 0.
- Forward priority:
  - Stimulus: rs_e[1] = 3, prod slots 1 and 2 both writing x3.
  - Response: fwd_sel[1] = 1. With rs_e[1] = 0 and matching rd = 0: fwd_sel = 0.
- IRQ drain:
  - Stimulus: irq_pend = irq_en = 1, valid_i = 4'b1110, clearing one stage per cycle.
  - Response: DRAIN for 3 cycles with stall_o[0] = 1, then take_irq_o = 1 for one cycle with pc_sel = 1 and new_pc_en = 1.
- IRQ cancelled:
  - Stimulus: enter DRAIN, then irq_en = 0.
  - Response: next cycle state = RUN, no take pulse, stall released.
- Redirect priority:
  - Stimulus: trap_i, mret_i, branch_i and csr_wr_i all asserted together.
  - Response: pc_sel = 2, new_pc_en = 1, flush_o[2:0] = 3'b111.
  - Stimulus: branch_i alone.
  - Response: flush_o = 4'b0011, pc_sel = 0.
- Reset and counters:
  - Stimulus: rst_i asserted mid-DRAIN.
  - Response: RUN, take_irq_o = 0.
  - With HAZARD_PERF_CNT_EN: 10 stall cycles give perf_stall_cnt_o = 10; rst_i gives 0.

Source files
------------

// File: rtl/hazard_ctrl_param_if.sv
// Pipeline-side bundle of the hazard controller: operand/producer info, per-stage valid/stall/flush, redirect and IRQ.
// Purely combinational wiring; no handshake of its own, the slave modport is the controller.
interface hazard_ctrl_param_if #(
   parameter int NUM_RS     = 2,
   parameter int NUM_PROD   = 3,
   parameter int NUM_STAGES = 4,
   parameter int REG_AW     = 5,
   parameter int SELW       = $clog2(NUM_PROD)
);
   logic [NUM_RS*REG_AW-1:0]   rs_d_i;
   logic [NUM_RS*REG_AW-1:0]   rs_e_i;
   logic [NUM_PROD*REG_AW-1:0] prod_rd_i;
   logic [NUM_PROD-1:0]        prod_wr_i;
   logic [NUM_PROD-1:0]        prod_rdy_i;
   logic [NUM_RS*SELW-1:0]     fwd_sel_o;
   logic [NUM_STAGES-1:0]      valid_i;
   logic [NUM_STAGES-1:0]      stall_req_i;
   logic [NUM_STAGES-1:0]      flush_req_i;
   logic [NUM_STAGES-1:0]      stall_o;
   logic [NUM_STAGES-1:0]      flush_o;
   logic                       trap_i;
   logic                       mret_i;
   logic                       branch_i;
   logic                       csr_wr_i;
   logic                       irq_pend_i;
   logic                       irq_en_i;
   logic                       new_pc_en_o;
   logic [1:0]                 pc_sel_o;
   logic                       take_irq_o;

   modport master (
      output rs_d_i, rs_e_i, prod_rd_i, prod_wr_i, prod_rdy_i,
      output valid_i, stall_req_i, flush_req_i,
      output trap_i, mret_i, branch_i, csr_wr_i, irq_pend_i, irq_en_i,
      input  fwd_sel_o, stall_o, flush_o, new_pc_en_o, pc_sel_o, take_irq_o
   );

   modport slave (
      input  rs_d_i, rs_e_i, prod_rd_i, prod_wr_i, prod_rdy_i,
      input  valid_i, stall_req_i, flush_req_i,
      input  trap_i, mret_i, branch_i, csr_wr_i, irq_pend_i, irq_en_i,
      output fwd_sel_o, stall_o, flush_o, new_pc_en_o, pc_sel_o, take_irq_o
   );
endinterface

// File: rtl/hazard_ctrl_param.sv
// Hazard controller: forwarding select, stall/bubble chain, fetch redirect, IRQ drain FSM; HAZARD_PERF_CNT_EN adds perf counters.
// Outputs are combinational except take_irq_o (registered); no backpressure, stalls are what it produces.
module hazard_ctrl_param #(
   parameter int NUM_RS     = 2,
   parameter int NUM_PROD   = 3,
   parameter int NUM_STAGES = 4,
   parameter int REG_AW     = 5,
   parameter int SELW       = $clog2(NUM_PROD)
) (
   input logic                clk_i,
   input logic                rst_i,
   hazard_ctrl_param_if.slave hz
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [31:0]        perf_stall_cnt_o,
   output logic [31:0]        perf_flush_cnt_o,
   output logic [15:0]        perf_irq_lat_o
`endif
);

   typedef enum logic [1:0] {RUN, DRAIN, TAKE} irq_state_e;

   localparam logic [1:0] PC_JUMP = 2'd0;
   localparam logic [1:0] PC_TRAP = 2'd1;
   localparam logic [1:0] PC_MEPC = 2'd2;
   localparam logic [1:0] PC_CSRW = 2'd3;

   irq_state_e                state_q, state_d;
   logic                      take_q;
   logic                      drain_stall;
   logic                      load_use;
   logic [NUM_RS-1:0]         hit;
   logic [NUM_RS*SELW-1:0]    fwd_sel;
   logic [NUM_STAGES-1:0]     int_flush, flush_cause, stall_cause, stall, flush;
   logic                      new_pc_en;
   logic [1:0]                pc_sel;
   logic                      irq_req;
   logic                      unused_valid0;

   assign irq_req       = hz.irq_pend_i & hz.irq_en_i;
   assign unused_valid0 = hz.valid_i[0];

   // Walking from the oldest slot down lets the youngest (lowest k) match win.
   always_comb begin
      fwd_sel = '0;
      for (int j = 0; j < NUM_RS; j++) begin
         for (int k = NUM_PROD-1; k >= 1; k--) begin
            if ((hz.rs_e_i[j*REG_AW +: REG_AW] != '0) && hz.prod_wr_i[k] &&
                (hz.prod_rd_i[k*REG_AW +: REG_AW] == hz.rs_e_i[j*REG_AW +: REG_AW]))
               fwd_sel[j*SELW +: SELW] = SELW'(k);
         end
      end
   end

   always_comb begin
      load_use = 1'b0;
      hit      = '0;
      for (int j = 0; j < NUM_RS; j++) begin
         for (int k = 0; k < NUM_PROD; k++) begin
            if (!hit[j] && (hz.rs_d_i[j*REG_AW +: REG_AW] != '0) && hz.prod_wr_i[k] &&
                (hz.prod_rd_i[k*REG_AW +: REG_AW] == hz.rs_d_i[j*REG_AW +: REG_AW])) begin
               hit[j] = 1'b1;
               if (!hz.prod_rdy_i[k])
                  load_use = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= RUN;
         take_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         take_q  <= (state_d == TAKE);
      end
   end

   always_comb begin
      state_d     = state_q;
      drain_stall = 1'b0;
      case (state_q)
         RUN:   if (irq_req) state_d = DRAIN;
         DRAIN: begin
            drain_stall = 1'b1;
            if (!irq_req || hz.trap_i)
               state_d = RUN;
            else if (hz.valid_i[NUM_STAGES-1:1] == '0)
               state_d = TAKE;
         end
         TAKE:    state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   always_comb begin
      new_pc_en = 1'b1;
      pc_sel    = PC_JUMP;
      if (hz.trap_i)
         pc_sel = hz.mret_i ? PC_MEPC : PC_TRAP;
      else if (state_q == TAKE)
         pc_sel = PC_TRAP;
      else if (hz.branch_i)
         pc_sel = PC_JUMP;
      else if (hz.csr_wr_i)
         pc_sel = PC_CSRW;
      else
         new_pc_en = 1'b0;
   end

   // A flush on a register masks its own stall cause, so flush always wins.
   always_comb begin
      int_flush = '0;
      for (int k = 0; k < NUM_STAGES; k++) begin
         if (k <= 2) int_flush[k] = hz.trap_i | hz.csr_wr_i;
         if (k <= 1) int_flush[k] = int_flush[k] | hz.branch_i;
      end
      int_flush[0]   = int_flush[0] | (state_q == TAKE);
      flush_cause    = int_flush | hz.flush_req_i;
      stall_cause    = hz.stall_req_i;
      stall_cause[0] = stall_cause[0] | load_use | drain_stall;
      stall_cause    = stall_cause & ~flush_cause;

      stall[NUM_STAGES-1] = stall_cause[NUM_STAGES-1];
      for (int k = NUM_STAGES-2; k >= 0; k--)
         stall[k] = stall_cause[k] | stall[k+1];

      flush[0] = flush_cause[0];
      for (int k = 1; k < NUM_STAGES; k++)
         flush[k] = flush_cause[k] | (stall[k-1] & ~stall[k]);
   end

   assign hz.fwd_sel_o   = fwd_sel;
   assign hz.stall_o     = stall;
   assign hz.flush_o     = flush;
   assign hz.new_pc_en_o = new_pc_en;
   assign hz.pc_sel_o    = pc_sel;
   assign hz.take_irq_o  = take_q;

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_cnt_q, flush_cnt_q;
   logic [15:0] irq_lat_q, drain_len_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
         irq_lat_q   <= '0;
         drain_len_q <= '0;
      end else begin
         if (stall[0] && (stall_cnt_q != '1))
            stall_cnt_q <= stall_cnt_q + 32'd1;
         if ((|int_flush) && (flush_cnt_q != '1))
            flush_cnt_q <= flush_cnt_q + 32'd1;
         if (state_q == DRAIN) begin
            if (drain_len_q != '1)
               drain_len_q <= drain_len_q + 16'd1;
            if (state_d == TAKE)
               irq_lat_q <= (drain_len_q != '1) ? drain_len_q + 16'd1 : drain_len_q;
         end else begin
            drain_len_q <= '0;
         end
      end
   end

   assign perf_stall_cnt_o = stall_cnt_q;
   assign perf_flush_cnt_o = flush_cnt_q;
   assign perf_irq_lat_o   = irq_lat_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl_param.sv
// Bench for hazard_ctrl_param: per-cycle vector table (state carried across rows) checked through an expectation queue.
module tb_hazard_ctrl_param;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   hazard_ctrl_param_if #(.NUM_RS(2), .NUM_PROD(3), .NUM_STAGES(4), .REG_AW(5)) hz ();

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] perf_stall_cnt, perf_flush_cnt;
   logic [15:0] perf_irq_lat;
`endif

   hazard_ctrl_param #(.NUM_RS(2), .NUM_PROD(3), .NUM_STAGES(4), .REG_AW(5)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .hz    (hz)
`ifdef HAZARD_PERF_CNT_EN
      ,
      .perf_stall_cnt_o (perf_stall_cnt),
      .perf_flush_cnt_o (perf_flush_cnt),
      .perf_irq_lat_o   (perf_irq_lat)
`endif
   );

   typedef struct {
      logic        rst;
      logic [9:0]  rs_d, rs_e;
      logic [14:0] prd;
      logic [2:0]  wr, rdy;
      logic [3:0]  vld, sreq, freq;
      logic        trap, mret, br, csr, pend, en;
      logic [3:0]  e_fwd, e_stall, e_flush;
      logic        e_nen, e_take;
      logic [1:0]  e_sel;
   } vec_t;

   vec_t tbl[$];
   vec_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   function automatic vec_t z();
      vec_t v;
      v.rst = 1'b0; v.rs_d = '0; v.rs_e = '0; v.prd = '0; v.wr = '0; v.rdy = '0;
      v.vld = '0; v.sreq = '0; v.freq = '0;
      v.trap = 1'b0; v.mret = 1'b0; v.br = 1'b0; v.csr = 1'b0; v.pend = 1'b0; v.en = 1'b0;
      v.e_fwd = '0; v.e_stall = '0; v.e_flush = '0; v.e_nen = 1'b0; v.e_take = 1'b0; v.e_sel = '0;
      return v;
   endfunction

   task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s vec %0d: got %0h expected %0h", nm, idx, act, exp);
      end
   endtask

   task automatic apply(input vec_t v, input int idx);
      vec_t e;
      @(posedge clk);
      #1;
      rst            = v.rst;
      hz.rs_d_i      = v.rs_d;  hz.rs_e_i     = v.rs_e;
      hz.prod_rd_i   = v.prd;   hz.prod_wr_i  = v.wr;   hz.prod_rdy_i = v.rdy;
      hz.valid_i     = v.vld;   hz.stall_req_i = v.sreq; hz.flush_req_i = v.freq;
      hz.trap_i      = v.trap;  hz.mret_i     = v.mret;
      hz.branch_i    = v.br;    hz.csr_wr_i   = v.csr;
      hz.irq_pend_i  = v.pend;  hz.irq_en_i   = v.en;
      exp_q.push_back(v);
      @(negedge clk);
      if (exp_q.size() == 0) begin
         total++; bad++;
         $display("FAIL scoreboard vec %0d: queue empty", idx);
      end else begin
         e = exp_q.pop_front();
         chk("fwd_sel", idx, 32'(hz.fwd_sel_o), 32'(e.e_fwd));
         chk("stall", idx, 32'(hz.stall_o), 32'(e.e_stall));
         chk("flush", idx, 32'(hz.flush_o), 32'(e.e_flush));
         chk("new_pc_en", idx, 32'(hz.new_pc_en_o), 32'(e.e_nen));
         chk("take_irq", idx, 32'(hz.take_irq_o), 32'(e.e_take));
         if (e.e_nen)
            chk("pc_sel", idx, 32'(hz.pc_sel_o), 32'(e.e_sel));
      end
   endtask

   initial begin
      vec_t v;
      hz.rs_d_i = '0; hz.rs_e_i = '0; hz.prod_rd_i = '0; hz.prod_wr_i = '0; hz.prod_rdy_i = '0;
      hz.valid_i = '0; hz.stall_req_i = '0; hz.flush_req_i = '0;
      hz.trap_i = 0; hz.mret_i = 0; hz.branch_i = 0; hz.csr_wr_i = 0; hz.irq_pend_i = 0; hz.irq_en_i = 0;

      // reset
      v = z(); v.rst = 1; tbl.push_back(v);
      v = z(); v.rst = 1; tbl.push_back(v);
      // load-use on slot 0, then result ready
      v = z(); v.prd[4:0] = 5; v.wr = 3'b001; v.rdy = 3'b110; v.rs_d[4:0] = 5;
      v.e_stall = 4'b0001; v.e_flush = 4'b0010; tbl.push_back(v);
      v.rdy = 3'b111; v.e_stall = 0; v.e_flush = 0; tbl.push_back(v);
      // ready younger match shadows a pending older one
      v = z(); v.prd[4:0] = 5; v.prd[9:5] = 5; v.wr = 3'b011; v.rdy = 3'b101; v.rs_d[4:0] = 5; tbl.push_back(v);
      // pending younger match on operand 1 stalls despite ready older one
      v = z(); v.prd[9:5] = 7; v.prd[14:10] = 7; v.wr = 3'b110; v.rdy = 3'b101; v.rs_d[9:5] = 7;
      v.e_stall = 4'b0001; v.e_flush = 4'b0010; tbl.push_back(v);
      // x0 never matches
      v = z(); v.wr = 3'b001; tbl.push_back(v);
      // forwarding priority: slot 1 over slot 2
      v = z(); v.rs_e[4:0] = 9; v.rs_e[9:5] = 3; v.prd[9:5] = 3; v.prd[14:10] = 3; v.wr = 3'b110;
      v.rdy = 3'b111; v.e_fwd = 4'b0100; tbl.push_back(v);
      // slot 0 not a forwarding source; slot 1 not writing -> slot 2
      v = z(); v.rs_e[4:0] = 4; v.prd[4:0] = 4; v.prd[9:5] = 4; v.prd[14:10] = 4; v.wr = 3'b101;
      v.rdy = 3'b111; v.e_fwd = 4'b0010; tbl.push_back(v);
      v = z(); v.wr = 3'b010; v.rdy = 3'b111; tbl.push_back(v);
      // redirect priority
      v = z(); v.trap = 1; v.mret = 1; v.br = 1; v.csr = 1; v.e_nen = 1; v.e_sel = 2; v.e_flush = 4'b0111; tbl.push_back(v);
      v = z(); v.trap = 1; v.e_nen = 1; v.e_sel = 1; v.e_flush = 4'b0111; tbl.push_back(v);
      v = z(); v.br = 1; v.e_nen = 1; v.e_sel = 0; v.e_flush = 4'b0011; tbl.push_back(v);
      v = z(); v.csr = 1; v.e_nen = 1; v.e_sel = 3; v.e_flush = 4'b0111; tbl.push_back(v);
      // external stall chain and bubble, flush masking stall
      v = z(); v.sreq = 4'b0100; v.e_stall = 4'b0111; v.e_flush = 4'b1000; tbl.push_back(v);
      v = z(); v.sreq = 4'b0100; v.freq = 4'b0100; v.e_flush = 4'b0100; tbl.push_back(v);
      v = z(); v.sreq = 4'b0001; v.br = 1; v.e_nen = 1; v.e_sel = 0; v.e_flush = 4'b0011; tbl.push_back(v);
      v = z(); v.sreq = 4'b1000; v.freq = 4'b1000; v.e_flush = 4'b1000; tbl.push_back(v);
      // IRQ drain: 3 drain cycles then one take cycle
      v = z(); v.pend = 1; v.en = 1; v.vld = 4'b1110; tbl.push_back(v);
      v = z(); v.pend = 1; v.en = 1; v.vld = 4'b1100; v.e_stall = 4'b0001; v.e_flush = 4'b0010; tbl.push_back(v);
      v.vld = 4'b1000; tbl.push_back(v);
      v.vld = 4'b0000; tbl.push_back(v);
      v = z(); v.e_take = 1; v.e_nen = 1; v.e_sel = 1; v.e_flush = 4'b0001; tbl.push_back(v);
      v = z(); tbl.push_back(v);
      // IRQ cancelled by enable dropping
      v = z(); v.pend = 1; v.en = 1; v.vld = 4'b0010; tbl.push_back(v);
      v = z(); v.pend = 1; v.vld = 4'b0010; v.e_stall = 4'b0001; v.e_flush = 4'b0010; tbl.push_back(v);
      v = z(); v.pend = 1; v.vld = 4'b0010; tbl.push_back(v);
      // trap during TAKE wins the redirect
      v = z(); v.pend = 1; v.en = 1; tbl.push_back(v);
      v = z(); v.pend = 1; v.en = 1; v.e_stall = 4'b0001; v.e_flush = 4'b0010; tbl.push_back(v);
      v = z(); v.trap = 1; v.mret = 1; v.e_take = 1; v.e_nen = 1; v.e_sel = 2; v.e_flush = 4'b0111; tbl.push_back(v);
      v = z(); tbl.push_back(v);
      // trap aborts DRAIN
      v = z(); v.pend = 1; v.en = 1; v.vld = 4'b1110; tbl.push_back(v);
      v = z(); v.pend = 1; v.en = 1; v.vld = 4'b1110; v.trap = 1; v.e_nen = 1; v.e_sel = 1; v.e_flush = 4'b0111; tbl.push_back(v);
      // reset mid-DRAIN
      v = z(); v.pend = 1; v.en = 1; v.vld = 4'b1110; tbl.push_back(v);
      v = z(); v.rst = 1; v.pend = 1; v.en = 1; v.vld = 4'b1110; v.e_stall = 4'b0001; v.e_flush = 4'b0010; tbl.push_back(v);
      v = z(); tbl.push_back(v);
      v = z(); tbl.push_back(v);

      for (int i = 0; i < tbl.size(); i++)
         apply(tbl[i], i);

`ifdef HAZARD_PERF_CNT_EN
      @(posedge clk); #1;
      rst = 1;
      @(posedge clk); #1;
      rst = 0;
      hz.stall_req_i = 4'b0001;
      repeat (10) @(posedge clk);
      #1;
      hz.stall_req_i = 4'b0000;
      chk("perf_stall_cnt", 0, perf_stall_cnt, 32'd10);
      rst = 1;
      @(posedge clk); #1;
      rst = 0;
      chk("perf_stall_cnt_rst", 0, perf_stall_cnt, 32'd0);
      chk("perf_flush_cnt_rst", 0, perf_flush_cnt, 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
